// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder word-access responder.
package mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_e;

   localparam int unsigned WORD_BYTES = 4;

   // A word access is legal only when aligned and entirely inside the RAM.
   function automatic logic word_addr_ok(input logic [31:0] addr, input int unsigned depth);
      logic [32:0] last;
      last = {1'b0, addr} + 33'(WORD_BYTES - 1);
      return (addr[1:0] == 2'b00) && (last < {1'b0, depth});
   endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// Byte-wide RAM with a big-endian 4-byte write port and combinational 4-byte read port.
module mem_byte_ram
   import mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_BYTES = 1024,
   localparam int unsigned AW = $clog2(DEPTH_BYTES)
) (
   input  logic          clock,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [7:0] mem [DEPTH_BYTES];

   // Most significant byte lives at the lowest address.
   always_ff @(posedge clock) begin
      if (we_i) begin
         for (int b = 0; b < WORD_BYTES; b++) begin
            mem[waddr_i + AW'(b)] <= wdata_i[31-8*b -: 8];
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      for (int b = 0; b < WORD_BYTES; b++) begin
         rdata_o[31-8*b -: 8] = mem[raddr_i + AW'(b)];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency word load/store responder over a byte RAM.
// Define MEM_RESPONDER_ERR_EN to report rejected requests on resp_err.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_BYTES = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW       = $clog2(DEPTH_BYTES);
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
`ifdef MEM_RESPONDER_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        run_q;
   logic        we_q;
   logic [31:0] addr_q, wdata_q;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        accept, addr_ok, ram_we;
   logic [31:0] ram_rdata;

   assign accept  = req_valid && req_ready;
   assign addr_ok = word_addr_ok(addr_q, DEPTH_BYTES);

   // run_q keeps req_ready low until the first edge after reset release.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         run_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         run_q   <= 1'b1;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         we_q    <= req_we;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = BUSY;
               cnt_d   = CNT_INIT;
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
               rdata_d = (!we_q && addr_ok) ? ram_rdata : '0;
               err_d   = ERR_EN && !addr_ok;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      ram_we     = 1'b0;
      case (state_q)
         IDLE:    req_ready  = run_q;
         BUSY:    ram_we     = (cnt_q == 4'd0) && we_q && addr_ok;
         RESP:    resp_valid = 1'b1;
         default: ;
      endcase
   end

   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   mem_byte_ram #(
      .DEPTH_BYTES(DEPTH_BYTES)
   ) u_ram (
      .clock  (clock),
      .we_i   (ram_we),
      .waddr_i(addr_q[AW-1:0]),
      .wdata_i(wdata_q),
      .raddr_i(addr_q[AW-1:0]),
      .rdata_o(ram_rdata)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver queues expected responses, monitor checks them.
module tb_mem_responder;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned LAT   = 2;
`ifdef MEM_RESPONDER_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_ready = 1'b1;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
      string       name;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   prev_valid = 1'b0;

   mem_responder #(
      .DEPTH_BYTES(DEPTH),
      .LATENCY    (LAT)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_err  (resp_err)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every cycle the response is presented it must match the queue head.
   always @(negedge clock) begin
      if (reset !== 1'b1) begin
         prev_valid = 1'b0;
      end else begin
         if (resp_valid) begin
            if (q.size() == 0) begin
               check("unexpected_resp", 32'd1, 32'd0);
            end else begin
               if (!prev_valid)
                  check({q[0].name, "/latency"}, 32'(cyc - q[0].acc), LAT);
               check({q[0].name, "/rdata"}, resp_rdata, q[0].rdata);
               check({q[0].name, "/err"}, {31'd0, resp_err}, {31'd0, q[0].err});
               check({q[0].name, "/req_ready_low"}, {31'd0, req_ready}, 32'd0);
               if (resp_ready) void'(q.pop_front());
            end
         end
         prev_valid = resp_valid;
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accept edge.
   task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
      exp_t e;
      bit   ok;
      ok        = 1'b0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clock);
         ok = req_ready;
      end
      if (!ok) begin
         check({name, "/accept_timeout"}, 32'd0, 32'd1);
         req_valid = 1'b0;
      end else begin
         e.rdata = exp_rd;
         e.err   = exp_err;
         e.acc   = cyc + 1;
         e.name  = name;
         q.push_back(e);
         @(posedge clock);
         #1;
         // Junk on the request bus while busy must not affect the access.
         req_valid = 1'b0;
         req_we    = ~we;
         req_addr  = 32'h0000_0010;
         req_wdata = 32'h5A5A_5A5A;
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clock);
      if (q.size() != 0) begin
         check("resp_timeout", 32'(q.size()), 32'd0);
         q.delete();
      end
      @(posedge clock);
      #1;
   endtask

   task automatic req_wait(input string name, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
      do_req(name, we, addr, wdata, exp_rd, exp_err);
      wait_done();
   endtask

   initial begin
      #3;
      check("rst/req_ready", {31'd0, req_ready}, 32'd0);
      check("rst/resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst/resp_rdata", resp_rdata, 32'd0);
      check("rst/resp_err", {31'd0, resp_err}, 32'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      check("rst_rel/req_ready_before_edge", {31'd0, req_ready}, 32'd0);
      @(posedge clock);
      #1;
      check("rst_rel/req_ready_after_edge", {31'd0, req_ready}, 32'd1);

      req_wait("st336", 1'b1, 32'd336, 32'h0000_00B4, 32'd0, 1'b0);
      req_wait("ld336", 1'b0, 32'd336, 32'd0, 32'h0000_00B4, 1'b0);

      req_wait("st4", 1'b1, 32'd4, 32'h0502_8293, 32'd0, 1'b0);
      check("ram4", {24'd0, dut.u_ram.mem[4]}, 32'h05);
      check("ram5", {24'd0, dut.u_ram.mem[5]}, 32'h02);
      check("ram6", {24'd0, dut.u_ram.mem[6]}, 32'h82);
      check("ram7", {24'd0, dut.u_ram.mem[7]}, 32'h93);
      req_wait("ld4", 1'b0, 32'd4, 32'd0, 32'h0502_8293, 1'b0);

      req_wait("st337_misaligned", 1'b1, 32'd337, 32'hFFFF_FFFF, 32'd0, ERR_EN);
      req_wait("ld336_after_bad", 1'b0, 32'd336, 32'd0, 32'h0000_00B4, 1'b0);
      req_wait("ld337_misaligned", 1'b0, 32'd337, 32'd0, 32'd0, ERR_EN);

      // Back-pressure: response held for 5 cycles with resp_ready low.
      resp_ready = 1'b0;
      do_req("ld4_hold", 1'b0, 32'd4, 32'd0, 32'h0502_8293, 1'b0);
      repeat (LAT - 1) @(posedge clock);
      repeat (5) @(posedge clock);
      #1;
      check("hold/resp_valid", {31'd0, resp_valid}, 32'd1);
      check("hold/resp_rdata", resp_rdata, 32'h0502_8293);
      resp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("hold/idle_req_ready", {31'd0, req_ready}, 32'd1);
      check("hold/resp_valid_low", {31'd0, resp_valid}, 32'd0);
      wait_done();

      req_wait("st1020", 1'b1, 32'd1020, 32'hCAFE_F00D, 32'd0, 1'b0);
      req_wait("ld1020_top", 1'b0, 32'd1020, 32'd0, 32'hCAFE_F00D, 1'b0);
      req_wait("ld1024_oob", 1'b0, 32'd1024, 32'd0, 32'd0, ERR_EN);
      req_wait("ld1022_oob", 1'b0, 32'd1022, 32'd0, 32'd0, ERR_EN);
      req_wait("st0", 1'b1, 32'd0, 32'h1122_3344, 32'd0, 1'b0);
      req_wait("st1024_oob", 1'b1, 32'd1024, 32'hDEAD_BEEF, 32'd0, ERR_EN);
      req_wait("ld0_after_oob", 1'b0, 32'd0, 32'd0, 32'h1122_3344, 1'b0);

      // Reset during BUSY of a store discards it.
      req_wait("st8_prior", 1'b1, 32'd8, 32'hA5A5_0008, 32'd0, 1'b0);
      do_req("st8_reset", 1'b1, 32'd8, 32'h1234_5678, 32'd0, 1'b0);
      reset = 1'b0;
      #1;
      check("busy_rst/req_ready", {31'd0, req_ready}, 32'd0);
      check("busy_rst/resp_valid", {31'd0, resp_valid}, 32'd0);
      check("busy_rst/resp_rdata", resp_rdata, 32'd0);
      check("busy_rst/resp_err", {31'd0, resp_err}, 32'd0);
      q.delete();
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1;
      check("busy_rst/req_ready_after", {31'd0, req_ready}, 32'd1);
      req_wait("ld8_after_reset", 1'b0, 32'd8, 32'd0, 32'hA5A5_0008, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 1024, meaning the byte-addressed RAM size; it is a power of two and at least 8.
REQ-002 SHALL have parameter LATENCY, default 2, meaning the cycles from request accept to resp_valid; the legal range is 1 to 15.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit: 1 means store word, 0 means load word.
REQ-008 SHALL have port req_addr, input, 32 bits: the byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: the store data.
REQ-010 SHALL have port resp_valid, output, 1 bit: a response is presented.
REQ-011 SHALL have port resp_ready, input, 1 bit: the initiator accepts the response.
REQ-012 SHALL have port resp_rdata, output, 32 bits: the load data.
REQ-013 SHALL have port resp_err, output, 1 bit: the request was rejected.

Function
REQ-014 SHALL use a three-state FSM: IDLE, BUSY, RESP.
REQ-015 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high on a rising edge.
REQ-016 SHALL, on accept, register req_we, req_addr and req_wdata, load the latency counter with LATENCY-1, and enter BUSY.
REQ-017 SHALL decrement the counter each cycle in BUSY; at zero it performs the access and enters RESP, so resp_valid rises exactly LATENCY cycles after the accept edge.
REQ-018 SHALL store words big-endian: byte[a] = data[31:24], byte[a+1] = data[23:16], byte[a+2] = data[15:8], byte[a+3] = data[7:0].
REQ-019 SHALL treat a request as invalid when addr[1:0] is not 00 or addr+3 is at least DEPTH_BYTES.
REQ-020 SHALL, for an invalid request, leave the RAM unchanged and return resp_rdata = 0; resp_err follows REQ-029/REQ-030.
REQ-021 SHALL return resp_rdata = 0 for a store.
REQ-022 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready is high; on that edge it returns to IDLE.
REQ-023 SHALL NOT accept a new request in the same cycle a response retires; accept occurs no earlier than the next cycle in IDLE.
REQ-024 SHALL ignore req_* inputs while not in IDLE; changes there have no effect.
REQ-025 SHALL make a load issued after a completed store to the same address return the stored word.

Reset
REQ-026 SHALL, while reset is low, immediately force: state = IDLE, counter = 0, req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-027 SHALL assert req_ready on the first rising edge after reset is deasserted.
REQ-028 SHALL NOT clear RAM contents on reset; a store in BUSY when reset asserts is discarded and the RAM is not written.

Configuration
REQ-029 SHALL, with macro MEM_RESPONDER_ERR_EN defined, drive resp_err = 1 in RESP for an invalid request and 0 otherwise.
REQ-030 SHALL, without MEM_RESPONDER_ERR_EN, tie resp_err to 0; invalid requests are still silently dropped and loads return 0.

Structure
REQ-031 SHALL place the FSM state enum (IDLE, BUSY, RESP) and the constant WORD_BYTES = 4 in package mem_responder_pkg.
REQ-032 SHALL contain one sub-module, mem_byte_ram: a DEPTH_BYTES x 8 array with a 4-byte big-endian write port and a 4-byte read port, read combinationally and written on the clock edge.

Verification
REQ-033 SHALL verify: store 0x000000B4 to addr 336, then load addr 336 -> resp_rdata = 0x000000B4, resp_err = 0, and resp_valid exactly 2 cycles after each accept.
REQ-034 SHALL verify: store 0x05028293 to addr 4 -> RAM bytes 4..7 = 05, 02, 82, 93.
REQ-035 SHALL verify: store 0xFFFFFFFF to addr 337, then load addr 336 -> 0x000000B4; the 337 response has resp_err = 1 with the macro, 0 without.
REQ-036 SHALL verify: hold resp_ready = 0 for 5 cycles -> resp_valid and resp_rdata stay stable, req_ready = 0 throughout, and the state returns to IDLE one edge after resp_ready rises.
REQ-037 SHALL verify: assert reset during BUSY of a store of 0x12345678 to addr 8 -> all outputs are 0 immediately, and a later load of addr 8 returns its prior value.
REQ-038 SHALL verify: load addr DEPTH_BYTES-4 -> valid; load addr DEPTH_BYTES -> resp_rdata = 0, resp_err = 1 with the macro.
